nts_ip_udp_csum: RTL and testbench

- Streaming checksum verifier that sits directly downstream of the Ethernet/IPv4/UDP header parser.
- Consumes the same 64-bit receive word stream and control strobes.
- Accumulates the IPv4 header checksum and the UDP checksum (pseudo-header plus segment) as words pass.
- Reports pass/fail per frame, so the NTS engine drops corrupted NTP requests before authentication.

---
 rtl/nts_ip_udp_csum.sv | 182 ++++++++++++++++++
 tb/tb_nts_ip_udp_csum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nts_ip_udp_csum.sv
// Streaming IPv4 header and UDP checksum verifier fed by the receive parser's word stream.
// Lanes are summed with an end-around carry every cycle; two fold cycles then finish both sums.
module nts_ip_udp_csum #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_clear,
    input  logic        i_process,
    input  logic        i_last,
    input  logic [7:0]  i_last_word_data_valid,
    input  logic [63:0] i_data,
    input  logic        i_detect_ipv4,
    input  logic        i_detect_ipv4_bad,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ip_csum_good,
    output logic        o_udp_csum_good,
    output logic        o_udp_csum_zero,
    output logic        o_len_bad
);

    localparam int BW = ADDR_WIDTH + 18;
    localparam logic [ADDR_WIDTH-1:0] IDX_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FOLD1, S_FOLD2, S_DONE} state_t;
    state_t state, state_next;

    logic [63:0]           prev_data;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  idx_full;
    logic                  overflow;
    logic [19:0]           ip_sum, udp_sum;
    logic [15:0]           udp_len;
    logic [7:0]            protocol;
    logic                  csum_zero;
    logic                  len_bad;

    logic                  first_word, add_en, last_overflow, frame_short, qualified;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [7:0]            byte_mask;
    logic [63:0]           word_masked;
    logic [BW-1:0]         word_base, udp_end, byte_count;
    logic [19:0]           ip_lanes, udp_lanes, ip_next, udp_next, ip_fold, udp_fold;

    function automatic logic [19:0] fold(input logic [19:0] s);
        return {4'd0, s[15:0]} + {16'd0, s[19:16]};
    endfunction

    // Any word consumed outside ACCUM opens a new frame as word 0.
    assign first_word    = (state != S_ACCUM);
    assign cur_idx       = first_word ? '0 : word_idx;
    assign add_en        = !(state == S_ACCUM && idx_full);
    assign last_overflow = !first_word && (overflow || idx_full);

    assign byte_mask   = i_last ? i_last_word_data_valid : 8'hFF;
    assign word_base   = BW'({cur_idx, 3'b000});
    assign udp_end     = BW'(udp_len) + BW'(34);
    assign byte_count  = word_base + BW'($countones(byte_mask));
    assign frame_short = (byte_count < udp_end) || (cur_idx < ADDR_WIDTH'(5)) || (udp_len < 16'd8);

    always_comb begin
        word_masked = prev_data;
        for (int j = 0; j < 8; j++)
            if (!byte_mask[7-j]) word_masked[63-8*j -: 8] = 8'h00;
    end

    always_comb begin : lane_sum
        logic [BW-1:0] off;
        logic [15:0]   lane;
        off       = '0;
        lane      = '0;
        ip_lanes  = '0;
        udp_lanes = '0;
        for (int k = 0; k < 4; k++) begin
            off  = word_base + BW'(2 * k);
            lane = word_masked[63-16*k -: 16];
            if (off >= BW'(14) && off <= BW'(32))
                ip_lanes = ip_lanes + {4'd0, lane};
            // Up to word 4 only the address and UDP header lanes can fall past byte 25.
            if (cur_idx < ADDR_WIDTH'(5)) begin
                if (off >= BW'(26))
                    udp_lanes = udp_lanes + {4'd0, lane};
            end else if (off < udp_end) begin
                if (udp_len[0] && off == udp_end - BW'(1))
                    lane[7:0] = 8'h00;
                udp_lanes = udp_lanes + {4'd0, lane};
            end
        end
        if (cur_idx == ADDR_WIDTH'(5))
            udp_lanes = udp_lanes + 20'h00011 + {4'd0, udp_len};
    end

    assign ip_fold   = fold(ip_sum);
    assign udp_fold  = fold(udp_sum);
    assign ip_next   = first_word ? ip_lanes  : ip_fold  + ip_lanes;
    assign udp_next  = first_word ? udp_lanes : udp_fold + udp_lanes;
    assign qualified = i_detect_ipv4 && !i_detect_ipv4_bad && (protocol == 8'd17) && !len_bad;
    assign o_busy    = (state == S_ACCUM) || (state == S_FOLD1) || (state == S_FOLD2);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (i_process) state_next = i_last ? S_FOLD1 : S_ACCUM;
            S_ACCUM:        if (i_process && i_last) state_next = S_FOLD1;
            S_FOLD1:        state_next = S_FOLD2;
            S_FOLD2:        state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset || i_clear) state <= S_IDLE;
        else                     state <= state_next;
    end

    // NOTE: prev_data is a pure alignment stage, always written before it is read, so it has no reset.
    always_ff @(posedge i_clk) prev_data <= i_data;

    always_ff @(posedge i_clk) begin
        if (i_areset || i_clear) begin
            word_idx        <= '0;
            idx_full        <= 1'b0;
            overflow        <= 1'b0;
            ip_sum          <= '0;
            udp_sum         <= '0;
            udp_len         <= '0;
            protocol        <= '0;
            csum_zero       <= 1'b0;
            len_bad         <= 1'b0;
            o_done          <= 1'b0;
            o_ip_csum_good  <= 1'b0;
            o_udp_csum_good <= 1'b0;
            o_udp_csum_zero <= 1'b0;
            o_len_bad       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE, S_ACCUM, S_DONE: begin
                    if (i_process) begin
                        if (first_word) begin
                            overflow        <= 1'b0;
                            csum_zero       <= 1'b0;
                            len_bad         <= 1'b0;
                            o_ip_csum_good  <= 1'b0;
                            o_udp_csum_good <= 1'b0;
                            o_udp_csum_zero <= 1'b0;
                            o_len_bad       <= 1'b0;
                        end
                        if (add_en) begin
                            ip_sum   <= ip_next;
                            udp_sum  <= udp_next;
                            idx_full <= (cur_idx == IDX_MAX);
                            if (cur_idx != IDX_MAX) word_idx <= cur_idx + 1'b1;
                            if (cur_idx == ADDR_WIDTH'(2)) protocol  <= word_masked[7:0];
                            if (cur_idx == ADDR_WIDTH'(4)) udp_len   <= word_masked[15:0];
                            if (cur_idx == ADDR_WIDTH'(5)) csum_zero <= (word_masked[63:48] == 16'h0000);
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (i_last) len_bad <= frame_short || last_overflow;
                    end
                end
                S_FOLD1: begin
                    ip_sum  <= ip_fold;
                    udp_sum <= udp_fold;
                end
                S_FOLD2: begin
                    ip_sum          <= ip_fold;
                    udp_sum         <= udp_fold;
                    o_done          <= 1'b1;
                    o_ip_csum_good  <= qualified && (ip_fold[15:0] == 16'hFFFF);
                    o_udp_csum_good <= qualified && (csum_zero || udp_fold[15:0] == 16'hFFFF);
                    o_udp_csum_zero <= csum_zero;
                    o_len_bad       <= len_bad;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nts_ip_udp_csum.sv
// Directed bench for nts_ip_udp_csum: frames are built byte-wise, checksums filled by a
// byte-level ones-complement model, and result flags compared against hand-derived values.
module tb_nts_ip_udp_csum;

    localparam int FRAME_MAX = 8200;

    logic        clk = 1'b0;
    logic        i_areset = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_process = 1'b0;
    logic        i_last = 1'b0;
    logic [7:0]  i_last_word_data_valid = 8'h00;
    logic [63:0] i_data = '0;
    logic        i_detect_ipv4 = 1'b1;
    logic        i_detect_ipv4_bad = 1'b0;
    logic        o_busy, o_done, o_ip_csum_good, o_udp_csum_good, o_udp_csum_zero, o_len_bad;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0]  frame [0:FRAME_MAX-1];
    logic [15:0] good_csum;

    nts_ip_udp_csum #(.ADDR_WIDTH(10)) dut (
        .i_clk                  (clk),
        .i_areset               (i_areset),
        .i_clear                (i_clear),
        .i_process              (i_process),
        .i_last                 (i_last),
        .i_last_word_data_valid (i_last_word_data_valid),
        .i_data                 (i_data),
        .i_detect_ipv4          (i_detect_ipv4),
        .i_detect_ipv4_bad      (i_detect_ipv4_bad),
        .o_busy                 (o_busy),
        .o_done                 (o_done),
        .o_ip_csum_good         (o_ip_csum_good),
        .o_udp_csum_good        (o_udp_csum_good),
        .o_udp_csum_zero        (o_udp_csum_zero),
        .o_len_bad              (o_len_bad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ones_sum(input int start, input int len, input logic [31:0] seed);
        logic [31:0] acc;
        logic [7:0]  lo;
        acc = seed;
        for (int i = start; i < start + len; i += 2) begin
            lo  = (i + 1 < start + len) ? frame[i+1] : 8'h00;
            acc = acc + {16'h0000, frame[i], lo};
        end
        while (acc[31:16] != 16'h0000) acc = {16'h0000, acc[15:0]} + {16'h0000, acc[31:16]};
        return acc[15:0];
    endfunction

    function automatic logic [63:0] get_word(input int w);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[63-8*j -: 8] = frame[8*w + j];
        return v;
    endfunction

    task automatic build(input logic [15:0] etype, input int udp_len, input int n_words, input logic [7:0] pad);
        logic [159:0] iph;
        logic [63:0]  udph;
        iph  = {16'h4500, 16'(20 + udp_len), 16'h0000, 16'h4000, 16'h4011, 16'h0000,
                32'hC0A80001, 32'hC0A800C7};
        udph = {16'h007B, 16'h007B, 16'(udp_len), 16'h0000};
        for (int i = 0; i < n_words * 8; i++) frame[i] = pad;
        for (int i = 0; i < 12; i++) frame[i] = (i == 5 || i == 11) ? 8'(i) : 8'h02;
        frame[12] = etype[15:8];
        frame[13] = etype[7:0];
        for (int i = 0; i < 20; i++) frame[14+i] = iph[159-8*i -: 8];
        for (int i = 0; i < 8; i++)  frame[34+i] = udph[63-8*i -: 8];
        for (int i = 42; i < 34 + udp_len; i++) frame[i] = 8'(i * 7 + 3);
    endtask

    // Fill IPv4 header checksum and UDP checksum (pseudo-header: addresses, 0x0011, length).
    task automatic seal(input int udp_len);
        logic [15:0] s;
        frame[24] = 8'h00; frame[25] = 8'h00;
        s = ~ones_sum(14, 20, 32'h0);
        frame[24] = s[15:8]; frame[25] = s[7:0];
        frame[40] = 8'h00; frame[41] = 8'h00;
        s = ~ones_sum(34, udp_len, {16'h0000, ones_sum(26, 8, 32'h0011 + 32'(udp_len))});
        if (s == 16'h0000) s = 16'hFFFF;
        frame[40] = s[15:8]; frame[41] = s[7:0];
    endtask

    // Returns on the falling edge right after the final word is consumed (state FOLD1).
    task automatic send_frame(input int nw, input logic [7:0] mask, input int clear_at);
        @(negedge clk);
        i_data = get_word(0);
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            i_process = 1'b1;
            i_last    = (w == nw - 1);
            i_last_word_data_valid = (w == nw - 1) ? mask : 8'h00;
            i_clear   = (w == clear_at);
            i_data    = (w + 1 < nw) ? get_word(w + 1) : 64'h0;
            if (w == clear_at) break;
        end
        @(negedge clk);
        i_process = 1'b0;
        i_last    = 1'b0;
        i_clear   = 1'b0;
        i_last_word_data_valid = 8'h00;
    endtask

    task automatic expect_frame(input string tag, input logic ip, input logic udp,
                                input logic zero, input logic lb);
        check({tag, " busy in fold"}, o_busy, 1'b1);
        check({tag, " done T+1"}, o_done, 1'b0);
        @(negedge clk);
        check({tag, " done T+2"}, o_done, 1'b0);
        @(negedge clk);
        check({tag, " done T+3"}, o_done, 1'b1);
        check({tag, " ip_good"}, o_ip_csum_good, ip);
        check({tag, " udp_good"}, o_udp_csum_good, udp);
        check({tag, " udp_zero"}, o_udp_csum_zero, zero);
        check({tag, " len_bad"}, o_len_bad, lb);
        @(negedge clk);
        check({tag, " done T+4"}, o_done, 1'b0);
        check({tag, " ip_good held"}, o_ip_csum_good, ip);
        check({tag, " busy after"}, o_busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        i_areset = 1'b0;
        check("reset busy", o_busy, 1'b0);
        check("reset done", o_done, 1'b0);
        check("reset ip_good", o_ip_csum_good, 1'b0);
        check("reset udp_good", o_udp_csum_good, 1'b0);
        check("reset udp_zero", o_udp_csum_zero, 1'b0);
        check("reset len_bad", o_len_bad, 1'b0);

        // Reference frame: header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, udp_len 0x5F.
        build(16'h0800, 95, 17, 8'hEE);
        seal(95);
        send_frame(17, 8'hFF, -1);
        expect_frame("valid", 1'b1, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        check("clear results ip_good", o_ip_csum_good, 1'b0);
        check("clear results udp_good", o_udp_csum_good, 1'b0);

        frame[25] = frame[25] + 8'd1;
        send_frame(17, 8'hFF, -1);
        expect_frame("ip corrupt", 1'b0, 1'b1, 1'b0, 1'b0);

        seal(95);
        good_csum = {frame[40], frame[41]};
        frame[40] = 8'h00; frame[41] = 8'h00;
        send_frame(17, 8'hFF, -1);
        expect_frame("udp csum zero", 1'b1, 1'b1, 1'b1, 1'b0);

        {frame[40], frame[41]} = (good_csum == 16'h1234) ? 16'h4321 : 16'h1234;
        send_frame(17, 8'hFF, -1);
        expect_frame("udp csum wrong", 1'b1, 1'b0, 1'b0, 1'b0);

        // Odd udp_len: payload 0xAB, pad bytes 0x5A must not leak into the sum.
        build(16'h0800, 9, 6, 8'h5A);
        frame[42] = 8'hAB;
        seal(9);
        send_frame(6, 8'hFE, -1);
        expect_frame("odd len", 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(6, 8'hC0, -1);    // 42 bytes delivered, 43 needed
        expect_frame("truncated", 1'b0, 1'b0, 1'b0, 1'b1);

        build(16'h86DD, 95, 17, 8'hEE);
        seal(95);
        i_detect_ipv4 = 1'b0;
        send_frame(17, 8'hFF, -1);
        expect_frame("not ipv4", 1'b0, 1'b0, 1'b0, 1'b0);
        i_detect_ipv4 = 1'b1;

        build(16'h0800, 95, 17, 8'hEE);
        seal(95);
        send_frame(17, 8'hFF, 3);
        check("mid clear busy", o_busy, 1'b0);
        check("mid clear done", o_done, 1'b0);
        check("mid clear len_bad", o_len_bad, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid clear no done", o_done, 1'b0);
        end
        send_frame(17, 8'hFF, -1);
        expect_frame("after clear", 1'b1, 1'b1, 1'b0, 1'b0);

        send_frame(17, 8'hFF, -1);
        i_areset = 1'b1;
        @(negedge clk);
        i_areset = 1'b0;
        check("fold reset busy", o_busy, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check("fold reset no done", o_done, 1'b0);
            @(negedge clk);
        end

        // Word-counter boundary: 1024 words fit, 1025 overflow.
        build(16'h0800, 95, 1025, 8'hEE);
        seal(95);
        send_frame(1024, 8'hFF, -1);
        expect_frame("1024 words", 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(1025, 8'hFF, -1);
        expect_frame("1025 words", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
